// File: rtl/mine_field_gen.sv
// Minesweeper mine-map generator: places NUM_MINES mines on an 8x16 grid from a
// Galois LFSR, keeps the first-click cell clear and answers registered cell queries.
module mine_field_gen #(
    parameter int          NUM_MINES = 10,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter logic [15:0] LFSR_TAPS = 16'hB400
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         seed_load,
    input  logic [15:0]  seed_in,
    input  logic         start,
    input  logic [6:0]   safe_idx,
    output logic         busy,
    output logic         done,
    output logic [127:0] mine_map,
    input  logic [6:0]   query_idx,
    output logic         query_mine,
    output logic [3:0]   query_count
);

    typedef enum logic [1:0] {IDLE, CLEAR, PLACE, DONE} state_t;

    localparam logic [6:0] MINE_TARGET = 7'(NUM_MINES);

    state_t         state_q, state_d;
    logic [15:0]    lfsr_q, lfsr_d;
    logic [127:0]   mine_map_q, mine_map_d;
    logic [6:0]     placed_q, placed_d;
    logic [6:0]     safe_q, safe_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           query_mine_q, query_mine_d;
    logic [3:0]     query_count_q, query_count_d;
    logic [6:0]     cand;

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        mine_map_d = mine_map_q;
        placed_d   = placed_q;
        safe_d     = safe_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cand       = lfsr_q[6:0];

        case (state_q)
            IDLE: begin
                // Seed is applied before start so a same-cycle start uses the new seed.
                if (seed_load) begin
                    lfsr_d = (seed_in == 16'h0000) ? SEED : seed_in;
                end
                if (start) begin
                    safe_d  = safe_idx;
                    busy_d  = 1'b1;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                mine_map_d = '0;
                placed_d   = '0;
                state_d    = PLACE;
            end
            PLACE: begin
                if (placed_q == MINE_TARGET) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
                    if ((cand != safe_q) && !mine_map_q[cand]) begin
                        mine_map_d[cand] = 1'b1;
                        placed_d         = placed_q + 7'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Off-grid neighbours are skipped rather than wrapped around the edges.
    always_comb begin : neighbour_count
        int nr;
        int nc;
        nr            = 0;
        nc            = 0;
        query_mine_d  = mine_map_q[query_idx];
        query_count_d = 4'd0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                nr = int'(query_idx[6:4]) + dr;
                nc = int'(query_idx[3:0]) + dc;
                if (!((dr == 0) && (dc == 0)) && (nr >= 0) && (nr < 8) && (nc >= 0) && (nc < 16)) begin
                    query_count_d = query_count_d + {3'b000, mine_map_q[7'(nr * 16 + nc)]};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            lfsr_q        <= SEED;
            mine_map_q    <= '0;
            placed_q      <= '0;
            safe_q        <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            query_mine_q  <= 1'b0;
            query_count_q <= 4'd0;
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            mine_map_q    <= mine_map_d;
            placed_q      <= placed_d;
            safe_q        <= safe_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            query_mine_q  <= query_mine_d;
            query_count_q <= query_count_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign mine_map    = mine_map_q;
    assign query_mine  = query_mine_q;
    assign query_count = query_count_q;

endmodule

// File: tb/tb_mine_field_gen.sv
// Bench for mine_field_gen: three instances (10, 127 and 0 mines) checked against
// a software model of the LFSR placement and a table of hand-computed queries.
module tb_mine_field_gen;

    localparam logic [15:0] SEED = 16'hACE1;

    logic         clk = 1'b0;
    logic         rst;
    logic         seed_load   [3];
    logic [15:0]  seed_in     [3];
    logic         start       [3];
    logic [6:0]   safe_idx    [3];
    logic         busy        [3];
    logic         done        [3];
    logic [127:0] mine_map    [3];
    logic [6:0]   query_idx   [3];
    logic         query_mine  [3];
    logic [3:0]   query_count [3];

    logic [15:0]  model_lfsr  [3];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mine_field_gen #(.NUM_MINES(10)) dut_n10 (
        .clk(clk), .rst(rst), .seed_load(seed_load[0]), .seed_in(seed_in[0]),
        .start(start[0]), .safe_idx(safe_idx[0]), .busy(busy[0]), .done(done[0]),
        .mine_map(mine_map[0]), .query_idx(query_idx[0]),
        .query_mine(query_mine[0]), .query_count(query_count[0]));

    mine_field_gen #(.NUM_MINES(127)) dut_n127 (
        .clk(clk), .rst(rst), .seed_load(seed_load[1]), .seed_in(seed_in[1]),
        .start(start[1]), .safe_idx(safe_idx[1]), .busy(busy[1]), .done(done[1]),
        .mine_map(mine_map[1]), .query_idx(query_idx[1]),
        .query_mine(query_mine[1]), .query_count(query_count[1]));

    mine_field_gen #(.NUM_MINES(0)) dut_n0 (
        .clk(clk), .rst(rst), .seed_load(seed_load[2]), .seed_in(seed_in[2]),
        .start(start[2]), .safe_idx(safe_idx[2]), .busy(busy[2]), .done(done[2]),
        .mine_map(mine_map[2]), .query_idx(query_idx[2]),
        .query_mine(query_mine[2]), .query_count(query_count[2]));

    typedef struct {
        int         d;
        logic [6:0] idx;
        logic       exp_mine;
        logic [3:0] exp_count;
    } qvec_t;

    qvec_t qv [13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int d, input logic [6:0] idx);
        query_idx[d] = idx;
        tick();
    endtask

    // Reference placement straight from the algorithm description.
    task automatic model_gen(input int d, input logic [6:0] safe, input int n,
                             output logic [127:0] map, output int steps);
        logic [15:0] l;
        logic [6:0]  c;
        int          placed;
        l      = model_lfsr[d];
        map    = '0;
        placed = 0;
        steps  = 0;
        while (placed < n && steps < 70000) begin
            c = l[6:0];
            l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
            steps++;
            if (c != safe && !map[c]) begin
                map[c] = 1'b1;
                placed++;
            end
        end
        model_lfsr[d] = l;
    endtask

    task automatic run_and_check(input int d, input int n, input logic [6:0] safe,
                                 input logic do_seed, input logic [15:0] seed,
                                 input logic disturb, input string name, output int lat);
        logic [127:0] exp_map;
        int           steps;
        logic         busy_bad;
        int           extra;
        if (do_seed) model_lfsr[d] = (seed == 16'h0000) ? SEED : seed;
        model_gen(d, safe, n, exp_map, steps);
        seed_load[d] = do_seed;
        seed_in[d]   = seed;
        start[d]     = 1'b1;
        safe_idx[d]  = safe;
        tick();
        start[d]     = 1'b0;
        seed_load[d] = 1'b0;
        lat          = 1;
        busy_bad     = 1'b0;
        while (!done[d] && lat < 20000) begin
            if (!busy[d]) busy_bad = 1'b1;
            if (disturb && (lat == 3 || lat == 6)) begin
                start[d]     = 1'b1;
                seed_load[d] = 1'b1;
                seed_in[d]   = 16'h5A5A;
                safe_idx[d]  = 7'd99;
            end else begin
                start[d]     = 1'b0;
                seed_load[d] = 1'b0;
            end
            tick();
            lat++;
        end
        start[d]     = 1'b0;
        seed_load[d] = 1'b0;
        checkOutput({name, "_latency"}, 128'(lat), 128'(steps + 3));
        checkOutput({name, "_map"}, mine_map[d], exp_map);
        checkOutput({name, "_busy_at_done"}, 128'(busy[d]), 128'(0));
        checkOutput({name, "_busy_during"}, 128'(busy_bad), 128'(0));
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done[d] || busy[d]) extra++;
        end
        checkOutput({name, "_single_done"}, 128'(extra), 128'(0));
    endtask

    initial begin
        int lat;
        int pop;
        for (int d = 0; d < 3; d++) begin
            seed_load[d]  = 1'b0;
            seed_in[d]    = 16'h0000;
            start[d]      = 1'b1;
            safe_idx[d]   = 7'd0;
            query_idx[d]  = 7'd17;
            model_lfsr[d] = SEED;
        end

        qv[0]  = '{1, 7'd0,   1'b0, 4'd3};
        qv[1]  = '{1, 7'd17,  1'b1, 4'd7};
        qv[2]  = '{1, 7'd15,  1'b1, 4'd3};
        qv[3]  = '{1, 7'd40,  1'b1, 4'd8};
        qv[4]  = '{1, 7'd1,   1'b1, 4'd4};
        qv[5]  = '{1, 7'd16,  1'b1, 4'd4};
        qv[6]  = '{1, 7'd127, 1'b1, 4'd3};
        qv[7]  = '{1, 7'd112, 1'b1, 4'd3};
        qv[8]  = '{1, 7'd8,   1'b1, 4'd5};
        qv[9]  = '{1, 7'd0,   1'b0, 4'd3};
        qv[10] = '{2, 7'd0,   1'b0, 4'd0};
        qv[11] = '{2, 7'd40,  1'b0, 4'd0};
        qv[12] = '{2, 7'd127, 1'b0, 4'd0};

        // Reset held with start asserted must not launch a generation.
        rst = 1'b0;
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("reset_outputs_%0d", d),
                        {busy[d], done[d], query_mine[d], query_count[d], mine_map[d]}, '0);
        end
        for (int d = 0; d < 3; d++) start[d] = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("post_reset_idle_%0d", d), {busy[d], done[d]}, '0);
        end

        run_and_check(0, 10, 7'd40, 1'b1, 16'h0001, 1'b0, "t2", lat);
        pop = $countones(mine_map[0]);
        checkOutput("t2_popcount", 128'(pop), 128'(10));
        checkOutput("t2_safe_clear", 128'(mine_map[0][40]), 128'(0));
        checkOutput("t2_latency_range", 128'(lat >= 13 && lat <= 500), 128'(1));

        run_and_check(0, 10, 7'd5, 1'b1, 16'h1234, 1'b1, "t5", lat);

        run_and_check(1, 127, 7'd0, 1'b0, 16'h0000, 1'b0, "t3", lat);
        checkOutput("t3_full_map", mine_map[1], ~128'h1);

        run_and_check(2, 0, 7'd9, 1'b0, 16'h0000, 1'b0, "t4", lat);
        checkOutput("t4_latency3", 128'(lat), 128'(3));
        checkOutput("t4_empty_map", mine_map[2], '0);

        for (int i = 0; i < 13; i++) begin
            applyStimulus(qv[i].d, qv[i].idx);
            checkOutput($sformatf("query%0d_mine", i), 128'(query_mine[qv[i].d]), 128'(qv[i].exp_mine));
            checkOutput($sformatf("query%0d_count", i), 128'(query_count[qv[i].d]), 128'(qv[i].exp_count));
        end

        // Reset in the middle of PLACE, then regenerate from the reset seed.
        safe_idx[0] = 7'd77;
        start[0]    = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checkOutput("t6_reset_map", mine_map[0], '0);
        checkOutput("t6_reset_busy", {busy[0], done[0]}, '0);
        for (int d = 0; d < 3; d++) model_lfsr[d] = SEED;
        run_and_check(0, 10, 7'd77, 1'b0, 16'h0000, 1'b0, "t6a", lat);
        run_and_check(0, 10, 7'd77, 1'b1, 16'h0000, 1'b0, "t6b_seed0", lat);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
